particle_double_buffer: RTL and testbench

PARTICLE_DOUBLE_BUFFER -- requirements
Module: particle_double_buffer

---
 rtl/particle_buf_pkg.sv | 22 ++
 rtl/particle_bank.sv | 35 +++
 rtl/particle_double_buffer.sv | 174 +++++++++++++++++
 tb/tb_particle_double_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/particle_buf_pkg.sv
// Shared types and constants for the particle double buffer: stream FSM states,
// default geometry and the packed particle field widths.
package particle_buf_pkg;

   localparam int PB_WIDTH_DEF = 32;
   localparam int PB_DEPTH_DEF = 1024;
   localparam int PB_X_W       = 16;
   localparam int PB_Y_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_PRESENT = 2'd3
   } strm_state_e;

   // Non-power-of-2 depths leave a hole at the top of the address space.
   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/particle_bank.sv
// One particle bank: single-clock dual-port RAM. Port A reads or writes, port B
// only reads; both read paths are two registered stages (RAM register + pipe register).
module particle_bank #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [WIDTH-1:0]  a_wdata,
   output logic [WIDTH-1:0]  a_rdata,
   input  logic              b_en,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [WIDTH-1:0]  b_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] a_q1, a_q2, b_q1, b_q2;

   always_ff @(posedge clk) begin
      if (a_en) begin
         if (a_we) mem[a_addr] <= a_wdata;
         else      a_q1 <= mem[a_addr];
      end
      if (b_en) b_q1 <= mem[b_addr];
      a_q2 <= a_q1;
      b_q2 <= b_q1;
   end

   assign a_rdata = a_q2;
   assign b_rdata = b_q2;

endmodule

// File: rtl/particle_double_buffer.sv
// Front/back particle buffer with frame-boundary swap and an optional render stream
// port, enabled by defining PARTICLE_BUF_STREAM_EN (default build: stream absent).
//
// state      | meaning
// IDLE       | no stream; swaps may execute, start accepted when no swap pending
// FETCH      | read of front[idx] issued on bank port B
// WAIT       | read data in the bank pipeline register
// PRESENT    | word idx offered on strm_*; advances on ready
module particle_double_buffer
   import particle_buf_pkg::*;
#(
   parameter int WIDTH = PB_WIDTH_DEF,
   parameter int DEPTH = PB_DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              swap_req_in,
   input  logic              upd_rd_en_in,
   input  logic [ADDR_W-1:0] upd_rd_addr_in,
   output logic              upd_rd_valid_out,
   output logic [WIDTH-1:0]  upd_rd_data_out,
   input  logic              upd_wr_en_in,
   input  logic [ADDR_W-1:0] upd_wr_addr_in,
   input  logic [WIDTH-1:0]  upd_wr_data_in,
   input  logic              strm_start_in,
   input  logic              strm_ready_in,
   output logic              strm_valid_out,
   output logic [ADDR_W-1:0] strm_addr_out,
   output logic [WIDTH-1:0]  strm_data_out,
   output logic              strm_busy_out,
   output logic              strm_done_out,
   output logic              front_bank_out,
   output logic              swap_pending_out
);

   logic             front_bank, swap_pending, swap_fire;
   logic             rd_ok, wr_ok;
   logic             rd_v1, rd_v2, rd_ok1, rd_ok2, rd_sel1, rd_sel2;
   logic             strm_idle, strm_fetch;
   logic [ADDR_W-1:0] strm_idx;
   logic [WIDTH-1:0] a_rdata [2];
   logic [WIDTH-1:0] b_rdata [2];

   assign rd_ok = upd_rd_en_in && addr_in_range(32'(upd_rd_addr_in), DEPTH);
   assign wr_ok = upd_wr_en_in && addr_in_range(32'(upd_wr_addr_in), DEPTH);

   // The front bank's port A serves update reads; the back bank's port A takes writes.
   for (genvar i = 0; i < 2; i++) begin : g_bank
      logic is_front;
      assign is_front = (front_bank == 1'(i));
      particle_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
         .clk     (clk_in),
         .a_en    (is_front ? rd_ok : wr_ok),
         .a_we    (!is_front),
         .a_addr  (is_front ? upd_rd_addr_in : upd_wr_addr_in),
         .a_wdata (upd_wr_data_in),
         .a_rdata (a_rdata[i]),
         .b_en    (is_front && strm_fetch),
         .b_addr  (strm_idx),
         .b_rdata (b_rdata[i])
      );
   end

   // Bank select travels with each read so a swap never redirects data already in flight.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_v1   <= 1'b0;
         rd_v2   <= 1'b0;
         rd_ok1  <= 1'b0;
         rd_ok2  <= 1'b0;
         rd_sel1 <= 1'b0;
         rd_sel2 <= 1'b0;
      end else begin
         rd_v1   <= upd_rd_en_in;
         rd_ok1  <= rd_ok;
         rd_sel1 <= front_bank;
         rd_v2   <= rd_v1;
         rd_ok2  <= rd_ok1;
         rd_sel2 <= rd_sel1;
      end
   end

   assign upd_rd_valid_out = rd_v2;
   assign upd_rd_data_out  = (rd_v2 && rd_ok2) ? a_rdata[rd_sel2] : '0;

   assign swap_fire = swap_pending && strm_idle && !(rd_v1 || rd_v2);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         front_bank   <= 1'b0;
         swap_pending <= 1'b0;
      end else begin
         if (swap_fire) front_bank <= ~front_bank;
         swap_pending <= (swap_pending || swap_req_in) && !swap_fire;
      end
   end

   assign front_bank_out   = front_bank;
   assign swap_pending_out = swap_pending;

`ifdef PARTICLE_BUF_STREAM_EN
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   strm_state_e       state;
   logic [ADDR_W-1:0] idx, addr_q;
   logic              valid_q, busy_q, done_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= ST_IDLE;
         idx     <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (strm_start_in && !swap_pending) begin
                  state  <= ST_FETCH;
                  idx    <= '0;
                  busy_q <= 1'b1;
               end
            end
            ST_FETCH: state <= ST_WAIT;
            ST_WAIT: begin
               state   <= ST_PRESENT;
               valid_q <= 1'b1;
               addr_q  <= idx;
            end
            ST_PRESENT: begin
               if (strm_ready_in) begin
                  valid_q <= 1'b0;
                  addr_q  <= '0;
                  if (idx == LAST_IDX) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state <= ST_FETCH;
                     idx   <= idx + ADDR_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign strm_idle      = (state == ST_IDLE);
   assign strm_fetch     = (state == ST_FETCH);
   assign strm_idx       = idx;
   assign strm_valid_out = valid_q;
   assign strm_addr_out  = addr_q;
   // Port B is not re-read while PRESENT, so its output register holds the word steady.
   assign strm_data_out  = valid_q ? b_rdata[front_bank] : '0;
   assign strm_busy_out  = busy_q;
   assign strm_done_out  = done_q;
`else
   logic unused_stream;
   assign unused_stream  = ^{strm_start_in, strm_ready_in, b_rdata[0], b_rdata[1]};
   assign strm_idle      = 1'b1;
   assign strm_fetch     = 1'b0;
   assign strm_idx       = '0;
   assign strm_valid_out = 1'b0;
   assign strm_addr_out  = '0;
   assign strm_data_out  = '0;
   assign strm_busy_out  = 1'b0;
   assign strm_done_out  = 1'b0;
`endif

endmodule

// File: tb/tb_particle_double_buffer.sv
// Bench for particle_double_buffer: directed swap/stream scenarios plus a randomized
// update-path run checked against a two-bank array model.
module tb_particle_double_buffer;
   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic swap_req = 1'b0, rd_en = 1'b0, wr_en = 1'b0, strm_start = 1'b0, strm_ready = 1'b0;
   logic [AW-1:0] rd_addr = '0, wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;

   logic rd_valid, strm_valid, strm_busy, strm_done, front, pending;
   logic [WIDTH-1:0] rd_data, strm_data;
   logic [AW-1:0] strm_addr;
   logic d6_rd_valid, d6_strm_valid, d6_strm_busy, d6_strm_done, d6_front, d6_pending;
   logic [WIDTH-1:0] d6_rd_data, d6_strm_data;
   logic [AW-1:0] d6_strm_addr;

   logic [WIDTH-1:0] m_mem [2][DEPTH];
   bit m_known [2][DEPTH];
   bit m_front = 1'b0, m_pending = 1'b0;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   particle_double_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk_in(clk), .rst_in(rst), .swap_req_in(swap_req),
      .upd_rd_en_in(rd_en), .upd_rd_addr_in(rd_addr),
      .upd_rd_valid_out(rd_valid), .upd_rd_data_out(rd_data),
      .upd_wr_en_in(wr_en), .upd_wr_addr_in(wr_addr), .upd_wr_data_in(wr_data),
      .strm_start_in(strm_start), .strm_ready_in(strm_ready),
      .strm_valid_out(strm_valid), .strm_addr_out(strm_addr), .strm_data_out(strm_data),
      .strm_busy_out(strm_busy), .strm_done_out(strm_done),
      .front_bank_out(front), .swap_pending_out(pending));

   // Non-power-of-2 depth sharing the same 3-bit address inputs.
   particle_double_buffer #(.WIDTH(WIDTH), .DEPTH(6)) u_dut6 (
      .clk_in(clk), .rst_in(rst), .swap_req_in(swap_req),
      .upd_rd_en_in(rd_en), .upd_rd_addr_in(rd_addr),
      .upd_rd_valid_out(d6_rd_valid), .upd_rd_data_out(d6_rd_data),
      .upd_wr_en_in(wr_en), .upd_wr_addr_in(wr_addr), .upd_wr_data_in(wr_data),
      .strm_start_in(strm_start), .strm_ready_in(strm_ready),
      .strm_valid_out(d6_strm_valid), .strm_addr_out(d6_strm_addr), .strm_data_out(d6_strm_data),
      .strm_busy_out(d6_strm_busy), .strm_done_out(d6_strm_done),
      .front_bank_out(d6_front), .swap_pending_out(d6_pending));

   task automatic idle_inputs();
      swap_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0; strm_start = 1'b0; strm_ready = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (front !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %b want 0", front); end
      n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      n_checks++; if (strm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_strm_valid: got %b want 0", strm_valid); end
      n_checks++; if (strm_busy !== 1'b0) begin n_fail++; $display("FAIL reset_strm_busy: got %b want 0", strm_busy); end
      n_checks++; if (strm_done !== 1'b0) begin n_fail++; $display("FAIL reset_strm_done: got %b want 0", strm_done); end
      n_checks++; if (strm_addr !== '0) begin n_fail++; $display("FAIL reset_strm_addr: got %h want 0", strm_addr); end
      n_checks++; if (strm_data !== '0) begin n_fail++; $display("FAIL reset_strm_data: got %h want 0", strm_data); end
      n_checks++; if (d6_front !== 1'b0) begin n_fail++; $display("FAIL reset_d6_front: got %b want 0", d6_front); end
      rst = 1'b0;
      m_front = 1'b0; m_pending = 1'b0;
   endtask

   task automatic test_swap_read();
      @(negedge clk); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h0001_0002;
      @(negedge clk); wr_en = 1'b0; swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0;
      n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL swap_pending_set: got %b want 1", pending); end
      n_checks++; if (front !== 1'b0) begin n_fail++; $display("FAIL swap_front_before: got %b want 0", front); end
      @(negedge clk);
      n_checks++; if (front !== 1'b1) begin n_fail++; $display("FAIL swap_front_after: got %b want 1", front); end
      n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL swap_pending_clr: got %b want 0", pending); end
      rd_en = 1'b1; rd_addr = 3'd5;
      @(negedge clk); rd_en = 1'b0;
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency_early: got %b want 0", rd_valid); end
      @(negedge clk);
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency_valid: got %b want 1", rd_valid); end
      n_checks++; if (rd_data !== 32'h0001_0002) begin n_fail++; $display("FAIL rd_addr5_data: got %h want 00010002", rd_data); end
      @(negedge clk);
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_single: got %b want 0", rd_valid); end
      m_front = 1'b1;
   endtask

   task automatic test_out_of_range();
      logic [WIDTH-1:0] v6, v1;
      v6 = $urandom; v1 = $urandom;
      @(negedge clk); wr_en = 1'b1; wr_addr = 3'd6; wr_data = v6;
      @(negedge clk); wr_addr = 3'd1; wr_data = v1;
      @(negedge clk); wr_en = 1'b0; swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0;
      @(negedge clk);
      n_checks++; if (front !== 1'b0) begin n_fail++; $display("FAIL oor_front: got %b want 0", front); end
      n_checks++; if (d6_front !== 1'b0) begin n_fail++; $display("FAIL oor_d6_front: got %b want 0", d6_front); end
      rd_en = 1'b1; rd_addr = 3'd6;
      @(negedge clk); rd_addr = 3'd1;
      @(negedge clk); rd_en = 1'b0;
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== v6) begin n_fail++; $display("FAIL d8_addr6: got %b/%h want 1/%h", rd_valid, rd_data, v6); end
      n_checks++; if (d6_rd_valid !== 1'b1 || d6_rd_data !== '0) begin n_fail++; $display("FAIL d6_addr6_zero: got %b/%h want 1/0", d6_rd_valid, d6_rd_data); end
      @(negedge clk);
      n_checks++; if (rd_data !== v1) begin n_fail++; $display("FAIL d8_addr1: got %h want %h", rd_data, v1); end
      n_checks++; if (d6_rd_valid !== 1'b1 || d6_rd_data !== v1) begin n_fail++; $display("FAIL d6_addr1: got %b/%h want 1/%h", d6_rd_valid, d6_rd_data, v1); end
      m_front = 1'b0;
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] p1_d = '0, p2_d = '0, nd, wd;
      bit p1_v = 0, p2_v = 0, p1_k = 0, p2_k = 0, nk, fire, we, re, sr;
      logic [AW-1:0] wa, ra;
      idle_inputs(); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      m_front = 1'b0; m_pending = 1'b0;
      for (int b = 0; b < 2; b++) for (int a = 0; a < DEPTH; a++) m_known[b][a] = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         n_checks++; if (rd_valid !== p2_v) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, rd_valid, p2_v); end
         if (p2_v && p2_k) begin
            n_checks++; if (rd_data !== p2_d) begin n_fail++; $display("FAIL rnd_data c=%0d: got %h want %h", c, rd_data, p2_d); end
         end
         n_checks++; if (front !== m_front) begin n_fail++; $display("FAIL rnd_front c=%0d: got %b want %b", c, front, m_front); end
         n_checks++; if (pending !== m_pending) begin n_fail++; $display("FAIL rnd_pending c=%0d: got %b want %b", c, pending, m_pending); end
         we = 0; re = 0; sr = 0; wa = '0; ra = '0; wd = $urandom;
         if (c < 8) begin we = 1; wa = AW'(c); end
         else if (c == 8 || c == 20) sr = 1;
         else if (c >= 12 && c < 20) begin we = 1; wa = AW'(c - 12); end
         else if (c >= 24 && c < 290) begin
            we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, DEPTH - 1)); ra = AW'($urandom_range(0, DEPTH - 1));
            sr = ($urandom_range(0, 11) == 0);
         end
         wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; swap_req = sr;
         fire = m_pending && !(p1_v || p2_v);
         nd = m_mem[m_front][ra]; nk = m_known[m_front][ra];
         if (we) begin m_mem[!m_front][wa] = wd; m_known[!m_front][wa] = 1'b1; end
         if (fire) begin m_front = !m_front; m_pending = 1'b0; end
         else if (sr) m_pending = 1'b1;
         p2_v = p1_v; p2_d = p1_d; p2_k = p1_k;
         p1_v = re; p1_d = nd; p1_k = nk;
      end
      idle_inputs();
   endtask

`ifdef PARTICLE_BUF_STREAM_EN
   task automatic test_stream_ready();
      int nvalid = 0, ndone = 0, last_c = -1, done_c = -2;
      @(negedge clk); strm_start = 1'b1; strm_ready = 1'b1;
      @(negedge clk); strm_start = 1'b0;
      n_checks++; if (strm_busy !== 1'b1) begin n_fail++; $display("FAIL strm_busy_start: got %b want 1", strm_busy); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (strm_valid === 1'b1) begin
            n_checks++; if (strm_addr !== AW'(nvalid)) begin n_fail++; $display("FAIL strm_order: got %0d want %0d", strm_addr, nvalid); end
            if (nvalid < DEPTH) begin
               n_checks++; if (strm_data !== m_mem[m_front][nvalid]) begin n_fail++; $display("FAIL strm_data idx=%0d: got %h want %h", nvalid, strm_data, m_mem[m_front][nvalid]); end
            end
            nvalid++; last_c = c;
         end
         if (strm_done === 1'b1) begin
            ndone++; done_c = c;
            n_checks++; if (strm_busy !== 1'b0) begin n_fail++; $display("FAIL strm_busy_done: got %b want 0", strm_busy); end
         end
      end
      n_checks++; if (nvalid != DEPTH) begin n_fail++; $display("FAIL strm_count: got %0d want %0d", nvalid, DEPTH); end
      n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL strm_done_pulses: got %0d want 1", ndone); end
      n_checks++; if (done_c != last_c + 1) begin n_fail++; $display("FAIL strm_done_timing: got %0d want %0d", done_c, last_c + 1); end
      idle_inputs();
   endtask

   task automatic test_stream_stall();
      int stalled = 0;
      bit done_seen = 0;
      @(negedge clk); strm_start = 1'b1; strm_ready = 1'b1;
      @(negedge clk); strm_start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (strm_done === 1'b1) done_seen = 1'b1;
         if (strm_valid === 1'b1 && strm_addr === 3'd3 && stalled < 10) begin
            n_checks++; if (strm_data !== m_mem[m_front][3]) begin n_fail++; $display("FAIL stall_data s=%0d: got %h want %h", stalled, strm_data, m_mem[m_front][3]); end
            stalled++; strm_ready = 1'b0;
         end else strm_ready = 1'b1;
      end
      n_checks++; if (stalled != 10) begin n_fail++; $display("FAIL stall_held: got %0d want 10", stalled); end
      n_checks++; if (!done_seen) begin n_fail++; $display("FAIL stall_done: got 0 want 1"); end
      idle_inputs();
   endtask

   task automatic test_swap_defer();
      int toggles = 0, tog_c = -1, done_c = -5;
      bit prev_front = m_front, saw_pending = 0;
      @(negedge clk); strm_start = 1'b1; strm_ready = 1'b1;
      @(negedge clk); strm_start = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (front !== prev_front) begin toggles++; tog_c = c; prev_front = front; end
         if (strm_done === 1'b1) done_c = c;
         if (strm_busy === 1'b1 && pending === 1'b1) saw_pending = 1'b1;
         swap_req = (strm_valid === 1'b1) && (strm_addr === 3'd1 || strm_addr === 3'd3 || strm_addr === 3'd5);
      end
      n_checks++; if (toggles != 1) begin n_fail++; $display("FAIL defer_toggles: got %0d want 1", toggles); end
      n_checks++; if (tog_c != done_c + 1) begin n_fail++; $display("FAIL defer_timing: got %0d want %0d", tog_c, done_c + 1); end
      n_checks++; if (!saw_pending) begin n_fail++; $display("FAIL defer_pending: got 0 want 1"); end
      m_front = !m_front;
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      bit aborted = 0;
      @(negedge clk); strm_start = 1'b1; strm_ready = 1'b1;
      @(negedge clk); strm_start = 1'b0;
      for (int c = 0; c < 40 && !aborted; c++) begin
         @(negedge clk);
         if (strm_valid === 1'b1 && strm_addr === 3'd4) begin rst = 1'b1; strm_ready = 1'b0; aborted = 1'b1; end
      end
      n_checks++; if (!aborted) begin n_fail++; $display("FAIL rstmid_reach4: got 0 want 1"); end
      @(negedge clk); rst = 1'b0;
      n_checks++; if (strm_valid !== 1'b0 || strm_busy !== 1'b0 || strm_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got v%b b%b d%b want 000", strm_valid, strm_busy, strm_done); end
      n_checks++; if (strm_addr !== '0 || strm_data !== '0) begin n_fail++; $display("FAIL rstmid_bus: got %h/%h want 0/0", strm_addr, strm_data); end
      n_checks++; if (front !== 1'b0 || pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_swap: got f%b p%b want 00", front, pending); end
      m_front = 1'b0; m_pending = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++; if (strm_done !== 1'b0 || strm_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone: got d%b b%b want 00", strm_done, strm_busy); end
      end
      swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0;
      @(negedge clk);
      n_checks++; if (front !== 1'b1) begin n_fail++; $display("FAIL rstmid_swap_after: got %b want 1", front); end
      rd_en = 1'b1; rd_addr = 3'd2;
      @(negedge clk); rd_en = 1'b0;
      @(negedge clk);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== m_mem[1][2]) begin n_fail++; $display("FAIL rstmid_retained: got %b/%h want 1/%h", rd_valid, rd_data, m_mem[1][2]); end
      m_front = 1'b1;
      idle_inputs();
   endtask
`else
   task automatic test_stream_disabled();
      @(negedge clk); strm_start = 1'b1; strm_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++; if (strm_valid !== 1'b0 || strm_busy !== 1'b0 || strm_done !== 1'b0) begin n_fail++; $display("FAIL nostrm_flags: got v%b b%b d%b want 000", strm_valid, strm_busy, strm_done); end
         n_checks++; if (strm_addr !== '0 || strm_data !== '0) begin n_fail++; $display("FAIL nostrm_bus: got %h/%h want 0/0", strm_addr, strm_data); end
      end
      swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0;
      n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL nostrm_pending: got %b want 1", pending); end
      @(negedge clk);
      n_checks++; if (front !== !m_front || pending !== 1'b0) begin n_fail++; $display("FAIL nostrm_swap: got f%b p%b want f%b p0", front, pending, !m_front); end
      m_front = !m_front;
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_swap_read();
      test_out_of_range();
      test_random();
`ifdef PARTICLE_BUF_STREAM_EN
      test_stream_ready();
      test_stream_stall();
      test_swap_defer();
      test_reset_mid();
`else
      test_stream_disabled();
`endif
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
